axil_mem_responder: RTL and testbench

//  AXI4-Lite responder (slave) memory answering the MEM-stage load/store initiator.

---
 rtl/axil_pkg.sv | 21 ++
 rtl/axil_mem_responder_lfsr8.sv | 26 ++
 rtl/axil_mem_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_axil_mem_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared response codes, FSM state types and latency counter width for axil_mem_responder
package axil_pkg;

    localparam int LAT_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/axil_mem_responder_lfsr8.sv
// rtl/axil_mem_responder_lfsr8.sv - 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5), present only when AXIL_MEM_RAND_LAT_EN is defined
// Ports: clk, rst_n (sync active-low), en (advance), q[7:0] (state)
`ifdef AXIL_MEM_RAND_LAT_EN
module lfsr8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
    assign q    = r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= 8'hA5;
        end else if (en) begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

endmodule
`endif

// File: rtl/axil_mem_responder.sv
// rtl/axil_mem_responder.sv - AXI4-Lite responder memory with independent read/write FSMs and configurable latency
// Ports: clk, rst_n (sync active-low); AR: araddr/arvalid/arready; R: rdata/rresp/rvalid/rready;
//        AW: awaddr/awvalid/awready; W: wdata/wstrb/wvalid/wready; B: bresp/bvalid/bready.
// Macro AXIL_MEM_RAND_LAT_EN: latencies come from an LFSR (lfsr[1:0] read, lfsr[3:2] write)
//        instead of RD_LATENCY/WR_LATENCY.
module axil_mem_responder
    import axil_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h8000_0000,
    parameter int                    RD_LATENCY  = 1,
    parameter int                    WR_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = $clog2(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic [LAT_W-1:0] w_rd_lat;
    logic [LAT_W-1:0] w_wr_lat;

`ifdef AXIL_MEM_RAND_LAT_EN
    logic [7:0] w_lfsr;
    logic       w_unused_lfsr;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (w_lfsr)
    );

    assign w_rd_lat      = {2'b00, w_lfsr[1:0]};
    assign w_wr_lat      = {2'b00, w_lfsr[3:2]};
    assign w_unused_lfsr = ^w_lfsr[7:4];
`else
    assign w_rd_lat = LAT_W'(RD_LATENCY);
    assign w_wr_lat = LAT_W'(WR_LATENCY);
`endif

    // ---------------- read channel ----------------
    rd_state_t             r_rd_state;
    rd_state_t             w_rd_next;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [LAT_W-1:0]      r_rd_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [ADDR_WIDTH-1:0] w_rd_off;
    logic                  w_rd_hit;
    logic [IDX_W-1:0]      w_rd_idx;

    // Offset subtraction wraps for addresses below BASE_ADDR, hence the explicit lower bound.
    assign w_rd_off = r_rd_addr - BASE_ADDR;
    assign w_rd_hit = (r_rd_addr >= BASE_ADDR) &&
                      (w_rd_off[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(DEPTH_WORDS));
    assign w_rd_idx = w_rd_off[IDX_W+1:2];

    assign arready = (r_rd_state == R_IDLE);
    assign rvalid  = (r_rd_state == R_RESP);
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

    always_ff @(posedge clk) begin
        if (!rst_n) r_rd_state <= R_IDLE;
        else        r_rd_state <= w_rd_next;
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (arvalid)         w_rd_next = R_WAIT;
            R_WAIT:  if (r_rd_cnt == '0)  w_rd_next = R_RESP;
            R_RESP:  if (rready)          w_rd_next = R_IDLE;
            default:                      w_rd_next = R_IDLE;
        endcase
    end

    // Sampling here sees the pre-commit array contents on a same-cycle write, so collisions return old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_addr <= '0;
            r_rd_cnt  <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_rd_addr <= araddr;
                        r_rd_cnt  <= w_rd_lat;
                    end
                end
                R_WAIT: begin
                    if (r_rd_cnt == '0) begin
                        r_rdata <= w_rd_hit ? r_mem[w_rd_idx] : '0;
                        r_rresp <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write channel ----------------
    wr_state_t             r_wr_state;
    wr_state_t             w_wr_next;
    logic                  r_aw_got;
    logic                  r_w_got;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [LAT_W-1:0]      r_wr_cnt;
    logic [1:0]            r_bresp;
    logic [ADDR_WIDTH-1:0] w_wr_off;
    logic                  w_wr_hit;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_commit;
    logic                  w_unused_addr;

    assign w_wr_off = r_wr_addr - BASE_ADDR;
    assign w_wr_hit = (r_wr_addr >= BASE_ADDR) &&
                      (w_wr_off[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(DEPTH_WORDS));
    assign w_wr_idx = w_wr_off[IDX_W+1:2];

    // Byte offset within the word is ignored on both channels.
    assign w_unused_addr = ^{w_rd_off[1:0], w_wr_off[1:0]};

    assign awready  = (r_wr_state == W_IDLE) && !r_aw_got;
    assign wready   = (r_wr_state == W_IDLE) && !r_w_got;
    assign bvalid   = (r_wr_state == W_RESP);
    assign bresp    = r_bresp;
    assign w_commit = (r_wr_state == W_WAIT) && (r_wr_cnt == '0) && w_wr_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) r_wr_state <= W_IDLE;
        else        r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (r_aw_got && r_w_got) w_wr_next = W_WAIT;
            W_WAIT:  if (r_wr_cnt == '0)      w_wr_next = W_RESP;
            W_RESP:  if (bready)              w_wr_next = W_IDLE;
            default:                          w_wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_wr_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wr_cnt  <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        r_wr_addr <= awaddr;
                        r_aw_got  <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        r_wdata <= wdata;
                        r_wstrb <= wstrb;
                        r_w_got <= 1'b1;
                    end
                    if (r_aw_got && r_w_got) begin
                        r_wr_cnt <= w_wr_lat;
                    end
                end
                W_WAIT: begin
                    if (r_wr_cnt == '0) begin
                        r_bresp <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_wr_cnt <= r_wr_cnt - 1'b1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_aw_got <= 1'b0;
                        r_w_got  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (r_wstrb[i]) r_mem[w_wr_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axil_mem_responder.sv
// tb/tb_axil_mem_responder.sv - scoreboard bench for axil_mem_responder
module tb_axil_mem_responder;

    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    axil_mem_responder #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (32'h8000_0000),
        .RD_LATENCY  (RD_LAT),
        .WR_LATENCY  (WR_LAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [int];
    logic [31:0] q_rdata [$];
    logic [1:0]  q_rresp [$];
    logic [1:0]  q_bresp [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8000_4000);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - 32'h8000_0000) >> 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_ar(input logic [31:0] addr);
        int n;
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            tick();
            n++;
        end
        if (!arready) chk("ar_timeout", 0, 1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] addr, input int hold);
        int          cyc;
        logic [31:0] e_data;
        logic [1:0]  e_resp;
        if (in_range(addr) && model.exists(idx_of(addr))) q_rdata.push_back(model[idx_of(addr)]);
        else                                               q_rdata.push_back(32'h0);
        q_rresp.push_back(in_range(addr) ? 2'b00 : 2'b10);
        issue_ar(addr);
        cyc = 0;
        while (!rvalid && cyc < 40) begin
            tick();
            cyc++;
        end
        e_data = q_rdata.pop_front();
        e_resp = q_rresp.pop_front();
        if (!rvalid) begin
            chk("rvalid_timeout", 0, 1);
            return;
        end
`ifndef AXIL_MEM_RAND_LAT_EN
        chk("rd_latency", cyc, 1 + RD_LAT);
`endif
        for (int i = 0; i < hold; i++) begin
            chk("r_hold_valid", rvalid, 1);
            chk("r_hold_data", rdata, e_data);
            chk("r_hold_arready", arready, 0);
            tick();
        end
        chk("rdata", rdata, e_data);
        chk("rresp", rresp, e_resp);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("r_after_hs", rvalid, 0);
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int aw_lead, input int w_lead);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        logic [31:0] m;
        if (in_range(addr)) begin
            m = model.exists(idx_of(addr)) ? model[idx_of(addr)] : 32'h0;
            for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = data[8*b +: 8];
            model[idx_of(addr)] = m;
        end
        q_bresp.push_back(in_range(addr) ? 2'b00 : 2'b10);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        aw_done = 1'b0;
        w_done  = 1'b0;
        for (int c = 0; c < 60 && !(aw_done && w_done); c++) begin
            awvalid = !aw_done && (c >= aw_lead);
            wvalid  = !w_done && (c >= w_lead);
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            tick();
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) chk("aw_w_timeout", 0, 1);
        cyc = 0;
        while (!bvalid && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!bvalid) begin
            chk("bvalid_timeout", 0, 1);
            void'(q_bresp.pop_front());
            return;
        end
        chk("bresp", bresp, q_bresp.pop_front());
        bready = 1'b1;
        tick();
        bready = 1'b0;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            if (bvalid) cyc++;
            tick();
        end
        chk("b_single_pulse", cyc, 0);
    endtask

    initial begin
        logic [31:0] a, d;
        rst_n   = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        repeat (3) tick();
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        rst_n = 1'b1;
        tick();

        write_word(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
        read_word(32'h8000_0010, 0);
        chk("t1_value", rdata, 32'hDEAD_BEEF);

        write_word(32'h8000_0010, 32'h0000_00AA, 4'b0001, 0, 2);
        read_word(32'h8000_0010, 0);
        chk("t2_value", rdata, 32'hDEAD_BEAA);

        write_word(32'h8000_0020, 32'h1234_5678, 4'hF, 3, 0);
        read_word(32'h8000_0020, 0);

        write_word(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 0);
        read_word(32'h7FFF_FFFC, 0);
        chk("t4_oor_rdata", rdata, 0);
        write_word(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 0);
        read_word(32'h8000_0000, 0);

        read_word(32'h8000_0010, 5);

        issue_ar(32'h8000_0020);
        rst_n = 1'b0;
        tick();
        chk("t6_rvalid", rvalid, 0);
        chk("t6_arready", arready, 1);
        rst_n = 1'b1;
        tick();
        read_word(32'h8000_0020, 0);

        for (int k = 0; k < 6; k++) begin
            a = 32'h8000_0000 + ($urandom_range(64, 127) << 2);
            d = $urandom;
            write_word(a, d, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2));
            write_word(a, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
            read_word(a, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
